rect_pos_ctl: RTL and testbench

Frame-synchronous position controller for the rectangle/image overlay stage of the VGA pipeline. Accepts new rectangle coordinates from any source (mouse, ADC channel selector, UI logic) over a valid/ready handshake, clamps them so the image stays on screen, and commits them only on the rising edge of vertical blank. This avoids tearing in the draw stage. Its `xpos`/`ypos` outputs drive the xpos/ypos inputs of the rectangle draw stage.

---
 rtl/rect_pos_pkg.sv | 18 +
 rtl/vblnk_edge_detect.sv | 24 ++
 rtl/rect_pos_ctl.sv | 101 ++++++++++
 tb/tb_rect_pos_ctl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rect_pos_pkg.sv
// rect_pos_pkg: state encoding, default screen/rectangle geometry and a slew step helper
package rect_pos_pkg;

    typedef enum logic [1:0] {IDLE, PENDING, CLAMP, COMMIT} state_t;

    localparam int DEF_H_RES    = 800;
    localparam int DEF_V_RES    = 600;
    localparam int DEF_RECT_W   = 48;
    localparam int DEF_RECT_H   = 64;
    localparam int DEF_MAX_STEP = 8;

    function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt,
                                                input logic [11:0] step);
        return (tgt > cur) ? ((tgt - cur > step) ? cur + step : tgt)
                           : ((cur - tgt > step) ? cur - step : tgt);
    endfunction

endpackage

// File: rtl/vblnk_edge_detect.sv
// vblnk_edge_detect: rising-edge detector on vertical blank with a registered frame tick
module vblnk_edge_detect (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk_in,
    output logic rise,
    output logic frame_tick
);

    logic vblnk_q;

    assign rise = vblnk_in & ~vblnk_q;

    always_ff @(posedge pclk) begin
        if (!rst) begin
            vblnk_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_q    <= vblnk_in;
            frame_tick <= rise;
        end
    end

endmodule

// File: rtl/rect_pos_ctl.sv
// rect_pos_ctl: frame-synchronous clamped rectangle position register for the overlay stage
// Optional per-frame slew limiting is enabled by defining RECT_POS_SLEW_EN.
module rect_pos_ctl
    import rect_pos_pkg::*;
#(
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int RECT_W   = DEF_RECT_W,
    parameter int RECT_H   = DEF_RECT_H,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_xpos,
    input  logic [11:0] req_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        upd_pulse,
    output logic        clamped,
    output logic        frame_tick
);

    localparam logic [11:0] X_MAX = 12'(H_RES - RECT_W);
    localparam logic [11:0] Y_MAX = 12'(V_RES - RECT_H);

    state_t      state, state_n;
    logic        rise, accept, cl_q, more;
    logic [11:0] tgt_x, tgt_y, tx, ty, nx, ny;

    vblnk_edge_detect u_edge (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .rise      (rise),
        .frame_tick(frame_tick)
    );

`ifdef RECT_POS_SLEW_EN
    localparam logic [11:0] STEP = 12'(MAX_STEP);
    assign nx   = step_toward(xpos, tx, STEP);
    assign ny   = step_toward(ypos, ty, STEP);
    assign more = (nx != tx) | (ny != ty);
`else
    assign nx   = tx;
    assign ny   = ty;
    assign more = 1'b0;
`endif

    assign req_ready = rst & (state == IDLE | state == PENDING);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? PENDING : IDLE;
            PENDING: state_n = rise ? CLAMP : PENDING;
            CLAMP:   state_n = COMMIT;
            COMMIT:  state_n = more ? PENDING : IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state     <= IDLE;
            tgt_x     <= '0;
            tgt_y     <= '0;
            tx        <= '0;
            ty        <= '0;
            cl_q      <= 1'b0;
            xpos      <= '0;
            ypos      <= '0;
            upd_pulse <= 1'b0;
            clamped   <= 1'b0;
        end else begin
            state     <= state_n;
            upd_pulse <= state == COMMIT;
            if (accept) begin
                tgt_x <= req_xpos;
                tgt_y <= req_ypos;
            end
            if (state == CLAMP) begin
                tx   <= (tgt_x > X_MAX) ? X_MAX : tgt_x;
                ty   <= (tgt_y > Y_MAX) ? Y_MAX : tgt_y;
                cl_q <= (tgt_x > X_MAX) | (tgt_y > Y_MAX);
            end
            if (state == COMMIT) begin
                xpos    <= nx;
                ypos    <= ny;
                clamped <= cl_q;
            end
        end
    end

    // Geometry sanity: the rectangle must fit on screen, otherwise the clamp limits wrap
    always_ff @(posedge pclk)
        assert (RECT_W <= H_RES && RECT_H <= V_RES && MAX_STEP > 0);

endmodule

// File: tb/tb_rect_pos_ctl.sv
// tb_rect_pos_ctl: directed self-checking bench for rect_pos_ctl
module tb_rect_pos_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_xpos = '0;
    logic [11:0] req_ypos = '0;
    logic [11:0] xpos, ypos;
    logic        upd_pulse, clamped, frame_tick;

    int n_chk = 0;
    int n_ok  = 0;

    rect_pos_ctl dut (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_xpos  (req_xpos),
        .req_ypos  (req_ypos),
        .xpos      (xpos),
        .ypos      (ypos),
        .upd_pulse (upd_pulse),
        .clamped   (clamped),
        .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [11:0] x, input logic [11:0] y);
        req_valid = 1'b1;
        req_xpos  = x;
        req_ypos  = y;
        tick();
        req_valid = 1'b0;
    endtask

    // Raise vblnk and expect a commit of (ex,ey) exactly two cycles after the edge cycle
    task automatic do_frame(input string tag, input logic [11:0] ex, input logic [11:0] ey,
                            input logic ecl);
        vblnk_in = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_ftick"}, frame_tick, 1);
        check({tag, "_upd_k"}, upd_pulse, 0);
        check({tag, "_rdy_clamp"}, req_ready, 0);
        tick();
        check({tag, "_upd_k1"}, upd_pulse, 0);
        tick();
        check({tag, "_upd_k2"}, upd_pulse, 1);
        check({tag, "_x"}, xpos, ex);
        check({tag, "_y"}, ypos, ey);
        check({tag, "_clamped"}, clamped, ecl);
        tick();
        check({tag, "_upd_off"}, upd_pulse, 0);
        check({tag, "_ftick_off"}, frame_tick, 0);
        vblnk_in = 1'b0;
        tick();
    endtask

    task automatic no_commit_frame(input string tag, input logic [11:0] ex, input logic [11:0] ey);
        vblnk_in = 1'b1;
        tick();
        check({tag, "_ftick"}, frame_tick, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_no_upd"}, upd_pulse, 0);
        end
        check({tag, "_x"}, xpos, ex);
        check({tag, "_y"}, ypos, ey);
        vblnk_in = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b1;
        req_xpos  = 12'd5;
        req_ypos  = 12'd5;
        repeat (4) tick();
        check("rst_x", xpos, 0);
        check("rst_y", ypos, 0);
        check("rst_ready", req_ready, 0);
        check("rst_upd", upd_pulse, 0);
        check("rst_ftick", frame_tick, 0);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rel_ready", req_ready, 1);
        tick();

        no_commit_frame("idle", 0, 0);

        send(12'd100, 12'd200);
        repeat (5) tick();
        check("wait_upd", upd_pulse, 0);
        check("wait_x", xpos, 0);
        check("wait_ready", req_ready, 1);
        do_frame("basic", 12'd100, 12'd200, 1'b0);

        send(12'd900, 12'd599);
        do_frame("clamp", 12'd752, 12'd536, 1'b1);
        send(12'd10, 12'd10);
        do_frame("unclamp", 12'd10, 12'd10, 1'b0);

        send(12'd10, 12'd10);
        tick();
        req_valid = 1'b1;
        req_xpos  = 12'd20;
        req_ypos  = 12'd30;
        do_frame("lastwins", 12'd20, 12'd30, 1'b0);

        send(12'd300, 12'd300);
        vblnk_in = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        vblnk_in = 1'b0;
        tick();
        check("midrst_x", xpos, 0);
        check("midrst_y", ypos, 0);
        check("midrst_upd", upd_pulse, 0);
        check("midrst_clamped", clamped, 0);
        no_commit_frame("midrst", 0, 0);

`ifdef RECT_POS_SLEW_EN
        send(12'd20, 12'd4);
        do_frame("slew1", 12'd8, 12'd4, 1'b0);
        do_frame("slew2", 12'd16, 12'd4, 1'b0);
        do_frame("slew3", 12'd20, 12'd4, 1'b0);
        no_commit_frame("slew_done", 12'd20, 12'd4);
`endif

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
